// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM->WB write-back stage with elastic FIFO buffer and flush
module mem_wb_pipe #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic              whilo;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } entry_t;

    entry_t             slots [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on occupancy, so a pop while full cannot admit a push.
    assign mem_ready = (count != FULL_CNT);
    assign wb_valid  = (count != '0);
    assign push      = mem_valid & mem_ready;
    assign pop       = wb_valid & wb_ready;

    assign in_entry.wd    = mem_wd;
    assign in_entry.wreg  = mem_wreg;
    assign in_entry.wdata = mem_wdata;
    assign in_entry.whilo = mem_whilo;
    assign in_entry.hi    = mem_hi;
    assign in_entry.lo    = mem_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= in_entry;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Empty buffer presents an all-zero bundle so a bubble never writes the regfile.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = slots[rd_ptr];
        end
    end

    assign wb_wd    = head.wd;
    assign wb_wreg  = head.wreg & wb_valid;
    assign wb_wdata = head.wdata;
    assign wb_whilo = head.whilo & wb_valid;
    assign wb_hi    = head.hi;
    assign wb_lo    = head.lo;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - directed self-checking bench for mem_wb_pipe
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DEPTH=2 instance
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_wd = '0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic        mem_whilo = 1'b0;
    logic [31:0] mem_hi = '0;
    logic [31:0] mem_lo = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;

    // DEPTH=3 instance
    logic        f3 = 1'b0;
    logic        m3_valid = 1'b0;
    logic        m3_ready;
    logic [4:0]  m3_wd = '0;
    logic        m3_wreg = 1'b0;
    logic [31:0] m3_wdata = '0;
    logic        w3_valid;
    logic        w3_ready = 1'b0;
    logic [4:0]  w3_wd;
    logic        w3_wreg;
    logic [31:0] w3_wdata;
    logic        w3_whilo;
    logic [31:0] w3_hi;
    logic [31:0] w3_lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
    );

    mem_wb_pipe #(.ADDR_W(5), .DATA_W(32), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(f3),
        .mem_valid(m3_valid), .mem_ready(m3_ready), .mem_wd(m3_wd), .mem_wreg(m3_wreg),
        .mem_wdata(m3_wdata), .mem_whilo(1'b0), .mem_hi(32'h0), .mem_lo(32'h0),
        .wb_valid(w3_valid), .wb_ready(w3_ready), .wb_wd(w3_wd), .wb_wreg(w3_wreg),
        .wb_wdata(w3_wdata), .wb_whilo(w3_whilo), .wb_hi(w3_hi), .wb_lo(w3_lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic whilo,
                          input logic [31:0] hi, input logic [31:0] lo);
        mem_valid = v;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
        mem_whilo = whilo;
        mem_hi    = hi;
        mem_lo    = lo;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, wb_valid, 1'b0);
        check({tag, "_ready"}, mem_ready, 1'b1);
        check({tag, "_wd"}, wb_wd, 5'd0);
        check({tag, "_wreg"}, wb_wreg, 1'b0);
        check({tag, "_wdata"}, wb_wdata, 32'h0);
        check({tag, "_whilo"}, wb_whilo, 1'b0);
        check({tag, "_hi"}, wb_hi, 32'h0);
        check({tag, "_lo"}, wb_lo, 32'h0);
    endtask

    initial begin
        int in_idx;
        int out_idx;
        int occ;
        bit psh;
        bit pp;

        // 1. reset with mem_valid held high
        set_in(1'b1, 5'd7, 1'b1, 32'h123, 1'b1, 32'h55, 32'h66);
        step();
        step();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check_empty("rst");
        step();
        check_empty("rst_idle");
        check("rst_d3_valid", w3_valid, 1'b0);
        check("rst_d3_ready", m3_ready, 1'b1);

        // 2. pass-through
        wb_ready = 1'b1;
        set_in(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
        step();
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("pt_valid", wb_valid, 1'b1);
        check("pt_wd", wb_wd, 5'd5);
        check("pt_wdata", wb_wdata, 32'hDEADBEEF);
        check("pt_wreg", wb_wreg, 1'b1);
        step();
        check("pt_drain", wb_valid, 1'b0);
        check("pt_drain_wreg", wb_wreg, 1'b0);

        // 3. back-pressure, full-with-pop must not accept
        wb_ready = 1'b0;
        set_in(1'b1, 5'd1, 1'b1, 32'hA, 1'b0, 32'h0, 32'h0);
        step();
        check("bp_a_wd", wb_wd, 5'd1);
        check("bp_a_ready", mem_ready, 1'b1);
        set_in(1'b1, 5'd2, 1'b1, 32'hB, 1'b0, 32'h0, 32'h0);
        step();
        check("bp_full_ready", mem_ready, 1'b0);
        check("bp_head_wd", wb_wd, 5'd1);
        set_in(1'b1, 5'd3, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);
        step();
        check("bp_stable_wd", wb_wd, 5'd1);
        check("bp_stable_wdata", wb_wdata, 32'hA);
        check("bp_still_full", mem_ready, 1'b0);
        wb_ready = 1'b1;
        step();
        check("bp_b_wd", wb_wd, 5'd2);
        check("bp_b_ready", mem_ready, 1'b1);
        step();
        check("bp_c_wd", wb_wd, 5'd3);
        check("bp_c_wdata", wb_wdata, 32'hC);
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        step();
        check("bp_done", wb_valid, 1'b0);

        // zero-enable bundle still occupies a slot
        wb_ready = 1'b0;
        set_in(1'b1, 5'd9, 1'b0, 32'h99, 1'b0, 32'h0, 32'h0);
        step();
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("nop_valid", wb_valid, 1'b1);
        check("nop_wd", wb_wd, 5'd9);
        check("nop_wreg", wb_wreg, 1'b0);
        wb_ready = 1'b1;
        step();
        check("nop_drain", wb_valid, 1'b0);

        // 5. flush with 2 buffered entries alongside a push
        wb_ready = 1'b0;
        set_in(1'b1, 5'd11, 1'b1, 32'h11, 1'b0, 32'h0, 32'h0);
        step();
        set_in(1'b1, 5'd12, 1'b1, 32'h12, 1'b0, 32'h0, 32'h0);
        step();
        flush = 1'b1;
        set_in(1'b1, 5'd13, 1'b1, 32'h13, 1'b0, 32'h0, 32'h0);
        step();
        flush = 1'b0;
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("fl_valid", wb_valid, 1'b0);
        check("fl_ready", mem_ready, 1'b1);
        wb_ready = 1'b1;
        set_in(1'b1, 5'd14, 1'b1, 32'h14, 1'b0, 32'h0, 32'h0);
        step();
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("fl_next_wd", wb_wd, 5'd14);
        check("fl_next_valid", wb_valid, 1'b1);
        step();
        check("fl_next_drain", wb_valid, 1'b0);

        // flush with one entry and an acceptable push: push dropped
        wb_ready = 1'b0;
        set_in(1'b1, 5'd15, 1'b1, 32'h15, 1'b0, 32'h0, 32'h0);
        step();
        flush = 1'b1;
        set_in(1'b1, 5'd16, 1'b1, 32'h16, 1'b0, 32'h0, 32'h0);
        step();
        flush = 1'b0;
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("flp_valid", wb_valid, 1'b0);
        wb_ready = 1'b1;
        set_in(1'b1, 5'd17, 1'b1, 32'h17, 1'b0, 32'h0, 32'h0);
        step();
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("flp_next_wd", wb_wd, 5'd17);
        step();
        check("flp_drain", wb_valid, 1'b0);

        // 6. HI/LO bundle, held under back-pressure, then flushed
        wb_ready = 1'b0;
        set_in(1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h2);
        step();
        set_in(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        check("hl_whilo", wb_whilo, 1'b1);
        check("hl_hi", wb_hi, 32'h1);
        check("hl_lo", wb_lo, 32'h2);
        check("hl_wreg", wb_wreg, 1'b0);
        step();
        check("hl_hold_whilo", wb_whilo, 1'b1);
        check("hl_hold_lo", wb_lo, 32'h2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("hl_fl_whilo", wb_whilo, 1'b0);
        check("hl_fl_hi", wb_hi, 32'h0);
        check("hl_fl_valid", wb_valid, 1'b0);

        // 4. wrap on DEPTH=3 with wb_ready toggling
        in_idx = 0;
        out_idx = 0;
        occ = 0;
        for (int cyc = 0; cyc < 200 && out_idx < 10; cyc++) begin
            m3_valid = (in_idx < 10);
            m3_wdata = in_idx;
            m3_wd    = in_idx[4:0];
            m3_wreg  = 1'b1;
            w3_ready = cyc[0];
            check("wrap_ready", m3_ready, occ != 3);
            check("wrap_valid", w3_valid, occ != 0);
            psh = m3_valid && m3_ready;
            pp  = w3_valid && w3_ready;
            if (pp) begin
                check("wrap_data", w3_wdata, out_idx);
                out_idx++;
            end
            if (psh) in_idx++;
            occ = occ + int'(psh) - int'(pp);
            step();
        end
        m3_valid = 1'b0;
        w3_ready = 1'b0;
        check("wrap_out_count", out_idx, 10);
        check("wrap_in_count", in_idx, 10);
        check("wrap_empty", w3_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
